// File: rtl/debug_frame_assembler.sv
// Reassembles the UART debug dump frame into register words and a packed control word.
// Optional checksum byte and CSUM state enabled by defining DBG_CHECKSUM_EN.
module debug_frame_assembler #(
  parameter int unsigned NUM_REGS    = 32,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned TO_BIT      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [4:0]  word_idx,
  output logic [31:0] word_data,
  output logic [18:0] ctrl_word,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned IDX_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG,
    S_CTRL,
`ifdef DBG_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        byte_cnt, byte_cnt_nxt;
  logic [IDX_W-1:0]  reg_cnt, reg_cnt_nxt;
  logic [23:0]       shift, shift_nxt;
  logic [18:0]       shadow, shadow_nxt;
  logic [TO_BIT-1:0] to_cnt, to_cnt_nxt;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]        csum, csum_nxt;
`endif

  logic        word_valid_nxt, frame_done_nxt, frame_err_nxt, busy_nxt;
  logic [4:0]  word_idx_nxt;
  logic [31:0] word_data_nxt;
  logic [18:0] ctrl_word_nxt;
  logic [1:0]  err_code_nxt;

  logic in_frame_c, timeout_c, hdr_c;

  // A byte in the same cycle as the timeout wins.
  always_comb begin
    in_frame_c = (state == S_REG) || (state == S_CTRL)
`ifdef DBG_CHECKSUM_EN
                 || (state == S_CSUM)
`endif
                 ;
    timeout_c  = in_frame_c && !rx_done_tick && (to_cnt == TO_BIT'(TIMEOUT_CYC - 1));
    hdr_c      = rx_done_tick && (din == HEADER) && ((state == S_IDLE) || (state == S_DONE));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = hdr_c ? S_REG : S_IDLE;
      S_REG: begin
        if (timeout_c) state_nxt = S_IDLE;
        else if (rx_done_tick && byte_cnt == 2'd3 && reg_cnt == IDX_W'(NUM_REGS - 1))
          state_nxt = S_CTRL;
      end
      S_CTRL: begin
        if (timeout_c) state_nxt = S_IDLE;
        else if (rx_done_tick && byte_cnt == 2'd2)
`ifdef DBG_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
      end
`ifdef DBG_CHECKSUM_EN
      S_CSUM: begin
        if (timeout_c) state_nxt = S_IDLE;
        else if (rx_done_tick) state_nxt = (din == csum) ? S_DONE : S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    byte_cnt_nxt   = byte_cnt;
    reg_cnt_nxt    = reg_cnt;
    shift_nxt      = shift;
    shadow_nxt     = shadow;
`ifdef DBG_CHECKSUM_EN
    csum_nxt       = csum;
`endif
    to_cnt_nxt     = '0;
    word_valid_nxt = 1'b0;
    word_idx_nxt   = word_idx;
    word_data_nxt  = word_data;
    ctrl_word_nxt  = ctrl_word;
    frame_done_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    err_code_nxt   = err_code;
    busy_nxt       = (state_nxt != S_IDLE);

    if (in_frame_c && !rx_done_tick) to_cnt_nxt = to_cnt + TO_BIT'(1);

    case (state)
      S_IDLE, S_DONE: begin
        if (hdr_c) begin
          byte_cnt_nxt = '0;
          reg_cnt_nxt  = '0;
          shift_nxt    = '0;
          shadow_nxt   = '0;
`ifdef DBG_CHECKSUM_EN
          csum_nxt     = '0;
`endif
          err_code_nxt = 2'd0;
        end
      end
      S_REG: begin
        if (rx_done_tick) begin
`ifdef DBG_CHECKSUM_EN
          csum_nxt     = csum ^ din;
`endif
          byte_cnt_nxt = byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: shift_nxt[7:0]   = din;
            2'd1: shift_nxt[15:8]  = din;
            2'd2: shift_nxt[23:16] = din;
            default: begin
              word_valid_nxt = 1'b1;
              word_idx_nxt   = reg_cnt;
              word_data_nxt  = {din, shift};
              reg_cnt_nxt    = reg_cnt + IDX_W'(1);
            end
          endcase
        end
      end
      S_CTRL: begin
        if (rx_done_tick) begin
`ifdef DBG_CHECKSUM_EN
          csum_nxt = csum ^ din;
`endif
          byte_cnt_nxt = byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: shadow_nxt[7:0] = din;
            2'd1: shadow_nxt[15:8] = din;
            default: begin
              shadow_nxt[18:16] = din[2:0];
              byte_cnt_nxt      = '0;
            end
          endcase
        end
      end
`ifdef DBG_CHECKSUM_EN
      S_CSUM: begin
        if (rx_done_tick && din != csum) begin
          frame_err_nxt = 1'b1;
          err_code_nxt  = 2'd2;
        end
      end
`endif
      default: ;
    endcase

    // Partial word and shadow are discarded; strobed words stand.
    if (timeout_c) begin
      frame_err_nxt = 1'b1;
      err_code_nxt  = 2'd1;
      byte_cnt_nxt  = '0;
      shift_nxt     = '0;
      shadow_nxt    = '0;
    end

    if (state_nxt == S_DONE) begin
      frame_done_nxt = 1'b1;
      ctrl_word_nxt  = shadow_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      reg_cnt    <= '0;
      shift      <= '0;
      shadow     <= '0;
      to_cnt     <= '0;
`ifdef DBG_CHECKSUM_EN
      csum       <= '0;
`endif
      word_valid <= 1'b0;
      word_idx   <= '0;
      word_data  <= '0;
      ctrl_word  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
    end else begin
      byte_cnt   <= byte_cnt_nxt;
      reg_cnt    <= reg_cnt_nxt;
      shift      <= shift_nxt;
      shadow     <= shadow_nxt;
      to_cnt     <= to_cnt_nxt;
`ifdef DBG_CHECKSUM_EN
      csum       <= csum_nxt;
`endif
      word_valid <= word_valid_nxt;
      word_idx   <= word_idx_nxt;
      word_data  <= word_data_nxt;
      ctrl_word  <= ctrl_word_nxt;
      frame_done <= frame_done_nxt;
      frame_err  <= frame_err_nxt;
      err_code   <= err_code_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_debug_frame_assembler.sv
// Scoreboard bench for debug_frame_assembler: expected words/frame events queued at
// stimulus time, a negedge monitor pops and compares whenever the DUT strobes.
module tb_debug_frame_assembler;

  localparam int unsigned NREG = 32;
  localparam logic [7:0]  HDR  = 8'hA5;
  localparam int unsigned TO   = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done_tick;
  logic [7:0]  din;
  logic        word_valid;
  logic [4:0]  word_idx;
  logic [31:0] word_data;
  logic [18:0] ctrl_word;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  debug_frame_assembler #(.NUM_REGS(NREG), .HEADER(HDR), .TIMEOUT_CYC(TO), .TO_BIT(20)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
    .word_valid(word_valid), .word_idx(word_idx), .word_data(word_data),
    .ctrl_word(ctrl_word), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] idx; logic [31:0] data; } wexp_t;
  typedef struct { bit is_err; logic [1:0] code; logic [18:0] ctrl; int delay; } evt_t;

  wexp_t exp_words[$];
  evt_t  exp_evts[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_byte_cyc = 0;
  logic [31:0] regs [NREG];
  logic [18:0] exp_ctrl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One byte strobe, captured at the next posedge; tick drops at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    din = b;
    @(posedge clk);
    #1 last_byte_cyc = cyc;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                            input logic [7:0] cs_flip);
    logic [7:0] cs;
    logic [7:0] b;
    evt_t e;
    cs = 8'h00;
    send_byte(HDR);
    check("hdr_busy", 64'(busy), 64'd1);
    check("hdr_clears_err", 64'(err_code), 64'd0);
    for (int r = 0; r < int'(NREG); r++) begin
      for (int k = 0; k < 4; k++) begin
        b = regs[r][8*k +: 8];
        cs ^= b;
        if (k == 3) exp_words.push_back('{idx: 5'(r), data: regs[r]});
        send_byte(b);
      end
    end
    cs = cs ^ c0 ^ c1 ^ c2;
    send_byte(c0);
    send_byte(c1);
`ifdef DBG_CHECKSUM_EN
    send_byte(c2);
    if (cs_flip != 8'h00) begin
      e = '{is_err: 1'b1, code: 2'd2, ctrl: exp_ctrl, delay: 0};
    end else begin
      exp_ctrl = {c2[2:0], c1, c0};
      e = '{is_err: 1'b0, code: 2'd0, ctrl: exp_ctrl, delay: 0};
    end
    exp_evts.push_back(e);
    send_byte(cs ^ cs_flip);
`else
    exp_ctrl = {c2[2:0], c1, c0};
    e = '{is_err: 1'b0, code: 2'd0, ctrl: exp_ctrl, delay: 0};
    exp_evts.push_back(e);
    send_byte(c2);
`endif
  endtask

  // Monitor: every strobe must match the head of its queue
  always @(negedge clk) begin
    if (!reset) begin
      if (word_valid) begin
        if (exp_words.size() == 0) begin
          check("word_unexpected", 64'(word_idx), 64'hFFFF);
        end else begin
          wexp_t w;
          w = exp_words.pop_front();
          check("word_idx", 64'(word_idx), 64'(w.idx));
          check("word_data", 64'(word_data), 64'(w.data));
        end
      end
      if (frame_done || frame_err) begin
        if (exp_evts.size() == 0) begin
          check("evt_unexpected", {62'd0, frame_done, frame_err}, 64'd0);
        end else begin
          evt_t e;
          e = exp_evts.pop_front();
          check("evt_kind_err", 64'(frame_err), 64'(e.is_err));
          check("evt_kind_done", 64'(frame_done), 64'(!e.is_err));
          check("evt_latency", 64'(cyc - last_byte_cyc), 64'(e.delay));
          check("evt_ctrl_word", 64'(ctrl_word), 64'(e.ctrl));
          if (e.is_err) check("evt_err_code", 64'(err_code), 64'(e.code));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    rx_done_tick = 1'b0;
    din = 8'h00;
    for (int r = 0; r < int'(NREG); r++) regs[r] = 32'h0100_0000 + 32'(r);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({word_valid, word_idx, word_data, ctrl_word,
                                frame_done, frame_err, err_code, busy}), 64'd0);
    reset = 1'b0;

    // Reset mid-REG after header + 9 register bytes
    send_byte(HDR);
    for (int i = 0; i < 9; i++) begin
      if (i % 4 == 3) exp_words.push_back('{idx: 5'(i / 4), data: regs[i / 4]});
      send_byte(regs[i / 4][8*(i % 4) +: 8]);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_outputs", 64'({word_valid, word_idx, word_data, ctrl_word,
                                   frame_done, frame_err, err_code}), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check("midreset_words_seen", 64'(exp_words.size()), 64'd0);

    // Junk bytes in IDLE, then a full frame
    send_byte(8'h00);
    send_byte(8'h33);
    check("idle_junk_busy", 64'(busy), 64'd0);
    send_frame(8'h1F, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("frameA_busy", 64'(busy), 64'd0);
    check("frameA_ctrl", 64'(ctrl_word), 64'h0001F);
    check("frameA_err_code", 64'(err_code), 64'd0);

`ifdef DBG_CHECKSUM_EN
    // Bad checksum: different control bytes must not reach ctrl_word
    send_frame(8'h00, 8'hAA, 8'h05, 8'h01);
    repeat (3) @(negedge clk);
    check("badcs_err_code", 64'(err_code), 64'd2);
    check("badcs_ctrl_kept", 64'(ctrl_word), 64'h0001F);
    check("badcs_busy", 64'(busy), 64'd0);
`endif

    // Header + 6 register bytes then silence: one word, timeout TO cycles later
    send_byte(HDR);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) exp_words.push_back('{idx: 5'd0, data: regs[0]});
      send_byte(regs[i / 4][8*(i % 4) +: 8]);
    end
    exp_evts.push_back('{is_err: 1'b1, code: 2'd1, ctrl: exp_ctrl, delay: int'(TO)});
    repeat (int'(TO) / 2) @(negedge clk);
    check("timeout_busy_before", 64'(busy), 64'd1);
    repeat (int'(TO)) @(negedge clk);
    check("timeout_err_code", 64'(err_code), 64'd1);
    check("timeout_busy_after", 64'(busy), 64'd0);

    // Header value as register data, plus ignored upper bits of control byte 2
    for (int r = 0; r < int'(NREG); r++) regs[r] = 32'h1111_1111 * 32'(r % 8) + 32'(r);
    regs[5] = 32'hA5A5_A5A5;
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'h00);
    repeat (2) @(negedge clk);
    check("frameB_ctrl", 64'(ctrl_word), 64'h7FFFF);
    send_byte(8'h7E);
    repeat (5) @(negedge clk);
    check("trailing_busy", 64'(busy), 64'd0);
    check("trailing_err_code", 64'(err_code), 64'd0);

    check("words_pending", 64'(exp_words.size()), 64'd0);
    check("events_pending", 64'(exp_evts.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
